// File: rtl/counter8_pkg.sv
// counter8_pkg: shared width constant and count type for counter8 and its
// sub-module.
//   CNT_WIDTH : default counter width
//   cnt_t     : count value at the default width
package counter8_pkg;

  localparam int CNT_WIDTH = 8;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage : counter8_pkg

// File: rtl/up_counter.sv
// up_counter: loadable up-counter with synchronous active-low reset.
// Priority on each rising clk edge: reset > ld > inc.
//   clk    : clock
//   reset  : synchronous reset, active low
//   ld     : load strobe, q <= ld_val
//   ld_val : load value
//   inc    : increment enable, wraps modulo 2^WIDTH
//   q      : registered count
module up_counter
  import counter8_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset)   r_q <= '0;
    else if (ld)  r_q <= ld_val;
    else if (inc) r_q <= r_q + WIDTH'(1);
  end

  assign q = r_q;

endmodule : up_counter

// File: rtl/counter8.sv
// counter8: free-running loadable up-counter plus a tally of accepted loads.
// Wiring only; all state lives in the two up_counter instances.
//   clk      : clock
//   reset    : synchronous reset, active low (overrides wr)
//   wdata    : load value, sampled when wr=1
//   wr       : load strobe, one load per high cycle
//   data_cnt : current count, registered
//   qa       : accepted loads since reset, registered, wraps
module counter8
  import counter8_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wr,
  output logic [WIDTH-1:0] data_cnt,
  output logic [WIDTH-1:0] qa
);

  logic             w_one;
  logic             w_zero;
  logic [WIDTH-1:0] w_zero_val;

  assign w_one      = 1'b1;
  assign w_zero     = 1'b0;
  assign w_zero_val = '0;

  // Data counter: loads on wr, otherwise always advances.
  up_counter #(.WIDTH(WIDTH)) u_data_cnt (
    .clk    (clk),
    .reset  (reset),
    .ld     (wr),
    .ld_val (wdata),
    .inc    (w_one),
    .q      (data_cnt)
  );

  // Write tally: never loaded, counts each cycle wr is high.
  up_counter #(.WIDTH(WIDTH)) u_wr_tally (
    .clk    (clk),
    .reset  (reset),
    .ld     (w_zero),
    .ld_val (w_zero_val),
    .inc    (wr),
    .q      (qa)
  );

endmodule : counter8

// File: tb/tb_counter8.sv
module tb_counter8;

  logic       clk;
  logic       reset;
  logic [7:0] wdata;
  logic       wr;
  logic [7:0] data_cnt;
  logic [7:0] qa;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: plain integers reduced modulo 256.
  int m_cnt = 0;
  int m_qa  = 0;

  counter8 #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wdata    (wdata),
    .wr       (wr),
    .data_cnt (data_cnt),
    .qa       (qa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model
  // from the spec rules, then compare DUT against the model on the falling edge.
  task automatic step(input logic rst, input logic w, input logic [7:0] d);
    reset = rst;
    wr    = w;
    wdata = d;
    @(posedge clk);
    if (!rst) begin
      m_cnt = 0;
      m_qa  = 0;
    end else if (w) begin
      m_cnt = int'(d);
      m_qa  = (m_qa + 1) % 256;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
    @(negedge clk);
    chk("model data_cnt", int'(data_cnt), m_cnt);
    chk("model qa",       int'(qa),       m_qa);
  endtask

  // Hand-computed expectation pinning the DUT (and thus the model) directly.
  task automatic lit(input string name, input int ecnt, input int eqa);
    chk({name, " data_cnt"}, int'(data_cnt), ecnt);
    chk({name, " qa"},       int'(qa),       eqa);
  endtask

  initial begin
    reset = 1'b0;
    wr    = 1'b0;
    wdata = 8'h00;
    @(negedge clk);

    // Reset held with a write pending: write ignored, not counted.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h55);
      lit("reset hold", 8'h00, 0);
    end

    // Release: counts 1..5.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 8'h00);
      lit("idle count", i, 0);
    end

    // Single write, then one idle cycle.
    step(1'b1, 1'b1, 8'h55);  lit("load 55", 8'h55, 1);
    step(1'b1, 1'b0, 8'h00);  lit("after 55", 8'h56, 1);

    // Wrap of data_cnt.
    step(1'b1, 1'b1, 8'hFE);  lit("load FE", 8'hFE, 2);
    step(1'b1, 1'b0, 8'h00);  lit("wrap FF", 8'hFF, 2);
    step(1'b1, 1'b0, 8'h00);  lit("wrap 00", 8'h00, 2);
    step(1'b1, 1'b0, 8'h00);  lit("wrap 01", 8'h01, 2);

    // Back-to-back writes.
    step(1'b1, 1'b1, 8'h10);  lit("b2b 10", 8'h10, 3);
    step(1'b1, 1'b1, 8'h20);  lit("b2b 20", 8'h20, 4);
    step(1'b1, 1'b1, 8'h30);  lit("b2b 30", 8'h30, 5);
    step(1'b1, 1'b0, 8'h00);  lit("b2b idle", 8'h31, 5);

    // Undefined wdata with wr low must not disturb the count.
    step(1'b1, 1'b0, 8'hxx);  lit("x wdata", 8'h32, 5);

    // Fresh reset, then 256 writes: qa passes 0xFF and wraps to 0.
    step(1'b0, 1'b0, 8'h00);  lit("re-reset", 8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 8'(i));
      if (i == 254) lit("qa 255", 8'hFE, 8'hFF);
    end
    lit("qa wrap", 8'hFF, 8'h00);

    // Reset coincident with a write: reset wins, write not counted.
    step(1'b1, 1'b1, 8'hA5);  lit("pre-reset load", 8'hA5, 1);
    step(1'b0, 1'b1, 8'h77);  lit("reset over wr", 8'h00, 0);
    step(1'b1, 1'b0, 8'h00);  lit("post reset", 8'h01, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_counter8
